// File: rtl/bfs_update_packer.sv
// ============================================================================
//  Module   : bfs_update_packer
//  Purpose  : Compacts per-lane BFS update words and packs them into 16-slot
//             512-bit writeback words, with end-of-iteration flush and count.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module bfs_update_packer #(
    parameter int          LANES = 8,
    parameter logic [31:0] PAD   = 32'hFFFF_FFFF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LANES*32-1:0] lane_word_in,
    input  logic [LANES-1:0]   lane_valid_in,
    input  logic [1:0]         control_in,
    input  logic               last_input_in,
    output logic [511:0]       packed_out,
    output logic               packed_valid,
    output logic [4:0]         packed_count,
    output logic               packed_last,
    output logic               done,
    output logic [31:0]        update_total
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] C_PHASE_UPDATE = 2'd2;

    state_t        state_q, state_d;
    logic [31:0]   mem_q [24];
    logic [31:0]   mem_d [24];
    logic [4:0]    count_q, count_d;
    logic [511:0]  packed_out_q, packed_out_d;
    logic          packed_valid_q, packed_valid_d;
    logic [4:0]    packed_count_q, packed_count_d;
    logic          packed_last_q, packed_last_d;
    logic          done_q, done_d;
    logic [31:0]   update_total_q, update_total_d;

    logic          w_phase_ok;
    logic          w_ingest;
    logic [31:0]   w_merged [24];
    logic [31:0]   w_shifted [24];
    logic [4:0]    w_fill;
    logic [4:0]    w_adds;
    logic [511:0]  w_word;

    assign w_phase_ok = (control_in == C_PHASE_UPDATE);
    assign w_ingest   = (state_q == S_RUN) && w_phase_ok;

    // Append valid lanes after existing entries; w_fill ends as T.
    always_comb begin
        w_merged = mem_q;
        w_fill   = count_q;
        for (int i = 0; i < LANES; i++) begin
            if (w_ingest && lane_valid_in[i] && (w_fill < 5'd24)) begin
                w_merged[w_fill] = lane_word_in[32*i +: 32];
                w_fill           = w_fill + 5'd1;
            end
        end
        w_adds = w_fill - count_q;
        for (int k = 0; k < 16; k++) begin
            w_word[32*k +: 32] = (5'(k) < w_fill) ? w_merged[k] : PAD;
        end
        for (int j = 0; j < 24; j++) begin
            w_shifted[j] = (j < 8) ? w_merged[j+16] : 32'd0;
        end
    end

    always_comb begin
        state_d        = state_q;
        mem_d          = mem_q;
        count_d        = count_q;
        packed_out_d   = packed_out_q;
        packed_valid_d = 1'b0;
        packed_count_d = packed_count_q;
        packed_last_d  = packed_last_q;
        done_d         = done_q;
        update_total_d = update_total_q;

        case (state_q)
            S_IDLE: begin
                count_d = 5'd0;
                if (w_phase_ok) begin
                    state_d        = S_RUN;
                    update_total_d = 32'd0;
                    done_d         = 1'b0;
                end
            end
            S_RUN: begin
                if (!w_phase_ok) begin
                    state_d = S_IDLE;
                    count_d = 5'd0;
                end else begin
                    update_total_d = update_total_q + {27'd0, w_adds};
                    if (w_fill >= 5'd16) begin
                        packed_valid_d = 1'b1;
                        packed_out_d   = w_word;
                        packed_count_d = 5'd16;
                        packed_last_d  = last_input_in && (w_fill == 5'd16);
                        mem_d          = w_shifted;
                        count_d        = w_fill - 5'd16;
                        if (last_input_in) begin
                            if (w_fill == 5'd16) begin
                                state_d = S_DONE;
                                done_d  = 1'b1;
                            end else begin
                                state_d = S_FLUSH;
                            end
                        end
                    end else begin
                        mem_d   = w_merged;
                        count_d = w_fill;
                        if (last_input_in) begin
                            packed_valid_d = 1'b1;
                            packed_out_d   = w_word;
                            packed_count_d = w_fill;
                            packed_last_d  = 1'b1;
                            count_d        = 5'd0;
                            state_d        = S_DONE;
                            done_d         = 1'b1;
                        end
                    end
                end
            end
            S_FLUSH: begin
                count_d = 5'd0;
                if (!w_phase_ok) begin
                    state_d = S_IDLE;
                end else begin
                    packed_valid_d = 1'b1;
                    packed_out_d   = w_word;
                    packed_count_d = count_q;
                    packed_last_d  = 1'b1;
                    state_d        = S_DONE;
                    done_d         = 1'b1;
                end
            end
            default: begin
                count_d = 5'd0;
                if (!w_phase_ok) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            count_q        <= 5'd0;
            for (int j = 0; j < 24; j++) begin
                mem_q[j] <= 32'd0;
            end
            packed_out_q   <= '0;
            packed_valid_q <= 1'b0;
            packed_count_q <= 5'd0;
            packed_last_q  <= 1'b0;
            done_q         <= 1'b0;
            update_total_q <= 32'd0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            mem_q          <= mem_d;
            packed_out_q   <= packed_out_d;
            packed_valid_q <= packed_valid_d;
            packed_count_q <= packed_count_d;
            packed_last_q  <= packed_last_d;
            done_q         <= done_d;
            update_total_q <= update_total_d;
        end
    end

    assign packed_out   = packed_out_q;
    assign packed_valid = packed_valid_q;
    assign packed_count = packed_count_q;
    assign packed_last  = packed_last_q;
    assign done         = done_q;
    assign update_total = update_total_q;

endmodule

`default_nettype wire

// File: tb/tb_bfs_update_packer.sv
// ============================================================================
//  Module   : tb_bfs_update_packer
//  Purpose  : Directed scoreboard bench for bfs_update_packer.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bfs_update_packer;

    localparam logic [31:0] C_PAD = 32'hFFFF_FFFF;

    logic          clk;
    logic          rst;
    logic [255:0]  lane_word_in;
    logic [7:0]    lane_valid_in;
    logic [1:0]    control_in;
    logic          last_input_in;
    logic [511:0]  packed_out;
    logic          packed_valid;
    logic [4:0]    packed_count;
    logic          packed_last;
    logic          done;
    logic [31:0]   update_total;

    bfs_update_packer #(.LANES(8), .PAD(C_PAD)) dut (
        .clk           (clk),
        .rst           (rst),
        .lane_word_in  (lane_word_in),
        .lane_valid_in (lane_valid_in),
        .control_in    (control_in),
        .last_input_in (last_input_in),
        .packed_out    (packed_out),
        .packed_valid  (packed_valid),
        .packed_count  (packed_count),
        .packed_last   (packed_last),
        .done          (done),
        .update_total  (update_total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [511:0] data;
        logic [4:0]   cnt;
        logic         last;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] es [16];
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Slots below n come from es[], the rest are PAD.
    task automatic push_exp(input int n, input logic lst);
        exp_t e;
        for (int k = 0; k < 16; k++) begin
            e.data[32*k +: 32] = (k < n) ? es[k] : C_PAD;
        end
        e.cnt  = 5'(n);
        e.last = lst;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic [7:0] v, input logic [1:0] ctl, input logic lst,
                        input logic [31:0] base);
        lane_valid_in = v;
        control_in    = ctl;
        last_input_in = lst;
        for (int i = 0; i < 8; i++) begin
            lane_word_in[32*i +: 32] = base + 32'(i);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && packed_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got count %0d last %0b expected none",
                         packed_count, packed_last);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("word_data",  packed_out, e.data);
                chk("word_count", {507'd0, packed_count}, {507'd0, e.cnt});
                chk("word_last",  {511'd0, packed_last}, {511'd0, e.last});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        step(8'h00, 2'd0, 1'b0, 32'd0);
        step(8'hFF, 2'd2, 1'b1, 32'd0);
        chk("rst_out",   packed_out, 512'd0);
        chk("rst_valid", {511'd0, packed_valid}, 512'd0);
        chk("rst_count", {507'd0, packed_count}, 512'd0);
        chk("rst_last",  {511'd0, packed_last}, 512'd0);
        chk("rst_done",  {511'd0, done}, 512'd0);
        chk("rst_total", {480'd0, update_total}, 512'd0);
        rst = 1'b0;

        // Full-word packing: 0..7 then 8..15
        step(8'h00, 2'd2, 1'b0, 32'd0);
        for (int k = 0; k < 16; k++) es[k] = 32'(k);
        push_exp(16, 1'b0);
        step(8'hFF, 2'd2, 1'b0, 32'd0);
        step(8'hFF, 2'd2, 1'b0, 32'd8);
        step(8'h00, 2'd2, 1'b0, 32'd0);
        chk("full_total", {480'd0, update_total}, 512'd16);
        chk("full_done_low", {511'd0, done}, 512'd0);
        push_exp(0, 1'b1);
        step(8'h00, 2'd2, 1'b1, 32'd0);
        chk("full_done", {511'd0, done}, 512'd1);
        step(8'h00, 2'd0, 1'b0, 32'd0);

        // Sparse compaction: A=0xA01, B=0xA05, C=0xC07
        step(8'h00, 2'd2, 1'b0, 32'd0);
        chk("sparse_total_clr", {480'd0, update_total}, 512'd0);
        chk("sparse_done_clr",  {511'd0, done}, 512'd0);
        step(8'b0010_0010, 2'd2, 1'b0, 32'hA00);
        step(8'b1000_0000, 2'd2, 1'b0, 32'hC00);
        es[0] = 32'hA01; es[1] = 32'hA05; es[2] = 32'hC07;
        push_exp(3, 1'b1);
        step(8'h00, 2'd2, 1'b1, 32'd0);
        chk("sparse_done",  {511'd0, done}, 512'd1);
        chk("sparse_total", {480'd0, update_total}, 512'd3);
        step(8'h00, 2'd0, 1'b0, 32'd0);

        // Overflow flush: 15 buffered, last with 8 valid
        step(8'h00, 2'd2, 1'b0, 32'd0);
        step(8'h7F, 2'd2, 1'b0, 32'h100);
        step(8'hFF, 2'd2, 1'b0, 32'h200);
        for (int k = 0; k < 7; k++) es[k] = 32'h100 + 32'(k);
        for (int k = 0; k < 8; k++) es[7+k] = 32'h200 + 32'(k);
        es[15] = 32'h300;
        push_exp(16, 1'b0);
        for (int k = 0; k < 7; k++) es[k] = 32'h301 + 32'(k);
        push_exp(7, 1'b1);
        step(8'hFF, 2'd2, 1'b1, 32'h300);
        chk("ovf_done_low", {511'd0, done}, 512'd0);
        step(8'h00, 2'd2, 1'b0, 32'd0);
        chk("ovf_done",  {511'd0, done}, 512'd1);
        chk("ovf_total", {480'd0, update_total}, 512'd23);
        step(8'h00, 2'd0, 1'b0, 32'd0);

        // Empty iteration
        step(8'h00, 2'd2, 1'b0, 32'd0);
        push_exp(0, 1'b1);
        step(8'h00, 2'd2, 1'b1, 32'd0);
        chk("empty_total", {480'd0, update_total}, 512'd0);
        chk("empty_done",  {511'd0, done}, 512'd1);
        step(8'h00, 2'd0, 1'b0, 32'd0);

        // Abort with 5 buffered, then re-enter
        step(8'h00, 2'd2, 1'b0, 32'd0);
        step(8'h1F, 2'd2, 1'b0, 32'h400);
        step(8'h00, 2'd0, 1'b0, 32'd0);
        chk("abort_done",  {511'd0, done}, 512'd0);
        chk("abort_total", {480'd0, update_total}, 512'd5);
        step(8'h00, 2'd2, 1'b0, 32'd0);
        push_exp(0, 1'b1);
        step(8'h00, 2'd2, 1'b1, 32'd0);
        chk("abort_reentry_done", {511'd0, done}, 512'd1);
        step(8'h00, 2'd0, 1'b0, 32'd0);

        // Reset mid-stream
        step(8'h00, 2'd2, 1'b0, 32'd0);
        step(8'h0F, 2'd2, 1'b0, 32'h500);
        rst = 1'b1;
        step(8'hFF, 2'd2, 1'b1, 32'h600);
        rst = 1'b0;
        chk("mrst_out",   packed_out, 512'd0);
        chk("mrst_count", {507'd0, packed_count}, 512'd0);
        chk("mrst_total", {480'd0, update_total}, 512'd0);
        chk("mrst_done",  {511'd0, done}, 512'd0);
        step(8'h00, 2'd2, 1'b0, 32'd0);
        push_exp(0, 1'b1);
        step(8'h00, 2'd2, 1'b1, 32'd0);
        step(8'h00, 2'd0, 1'b0, 32'd0);

        // Idle gating: control = 1 with valids and last
        step(8'hFF, 2'd1, 1'b1, 32'h700);
        step(8'hFF, 2'd1, 1'b1, 32'h700);
        chk("idle_total", {480'd0, update_total}, 512'd0);
        step(8'h00, 2'd2, 1'b0, 32'd0);
        push_exp(0, 1'b1);
        step(8'h00, 2'd2, 1'b1, 32'd0);
        step(8'h00, 2'd0, 1'b0, 32'd0);

        repeat (3) step(8'h00, 2'd0, 1'b0, 32'd0);
        chk("queue_drained", 512'(exp_q.size()), 512'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
